// File: rtl/bitfunc_serializer_pkg.sv
// Shared definitions for the bit-function serializer: mode codes, FSM encodings and
// the per-bit SHA-style function, also reused by the hash core.
package bitfunc_serializer_pkg;

  typedef enum logic [1:0] {
    MODE_CH  = 2'b00,
    MODE_MAJ = 2'b01,
    MODE_PAR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bitwise functions act on each bit position independently, so one bit is evaluated
  // here and callers replicate it across any word width.
  function automatic logic bitfunc_eval(input logic [1:0] mode, input logic a,
                                        input logic b, input logic c);
    logic r;
    case (mode)
      MODE_CH:  r = (a & b) ^ (~a & c);
      MODE_MAJ: r = (a & b) ^ (a & c) ^ (b & c);
      MODE_PAR: r = a ^ b ^ c;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitfunc_fifo.sv
// Synchronous result FIFO for the bit-function serializer; DEPTH must be a power of 2 so
// the pointers wrap naturally. Active-low synchronous reset clears pointers and count.
module bitfunc_fifo
  import bitfunc_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bitfunc_serializer.sv
// Mode-selected SHA-style bit function feeding a result FIFO, streamed out one bit per cycle.
// Build option BITFUNC_MSB_FIRST_EN: serialize MSB first (default is LSB first).
module bitfunc_serializer
  import bitfunc_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A_e,
  input  logic [WIDTH-1:0] B_e,
  input  logic [WIDTH-1:0] C_e,
  output logic             Yout,
  output logic             Yout_valid,
  output logic             Yout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]         fx;
  logic [WIDTH-1:0]         rd_data;
  logic [WIDTH-1:0]         sr;
  logic [CW-1:0]            bitcnt;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     last_bit;
  logic                     sr_bit;
  state_e                   state;
  state_e                   state_nxt;

  always_comb begin
    fx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fx[i] = bitfunc_eval(mode, A_e[i], B_e[i], C_e[i]);
    end
  end

  // Gating with reset keeps in_ready low for as long as reset is held.
  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;

  bitfunc_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (fx),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign last_bit = (bitcnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Popping on the last bit lets the next word follow with no idle cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr     <= '0;
      bitcnt <= '0;
    end else if (pop) begin
      sr     <= rd_data;
      bitcnt <= '0;
    end else if (state == ST_SHIFT) begin
`ifdef BITFUNC_MSB_FIRST_EN
      sr     <= {sr[WIDTH-2:0], 1'b0};
`else
      sr     <= {1'b0, sr[WIDTH-1:1]};
`endif
      bitcnt <= bitcnt + 1'b1;
    end
  end

`ifdef BITFUNC_MSB_FIRST_EN
  assign sr_bit = sr[WIDTH-1];
`else
  assign sr_bit = sr[0];
`endif

  assign Yout_valid = (state == ST_SHIFT);
  assign Yout       = Yout_valid && sr_bit;
  assign Yout_last  = Yout_valid && last_bit;
  assign busy       = (count != '0) || Yout_valid;

endmodule
